// File: rtl/rmii_pkg.sv
// Shared definitions for the RMII receive path.
// - rx_state_e        : receiver FSM states
// - FRAME_DIBITS      : dibits in a fixed 64-byte frame
// - MIN_PREAMBLE_DIBITS : preamble dibits required before SFD
// - CRC_POLY / CRC_RESIDUE : reflected CRC-32 constants
// - byte offsets of the fields the receiver inspects
// - mac_byte()        : picks wire-order byte k of a 48-bit MAC
package rmii_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREAMBLE  = 3'd1,
    FRAME     = 3'd2,
    CHECK     = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int FRAME_DIBITS        = 256;
  localparam int MIN_PREAMBLE_DIBITS = 8;
  localparam int PRE_CNT_MAX         = 31;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

  localparam int DST_OFS       = 0;
  localparam int MAC_BYTES     = 6;
  localparam int TYPE_OFS      = 12;
  localparam int PAYLOAD_FIRST = 12;
  localparam int PAYLOAD_LAST  = 18;

  // Byte k of a MAC address in wire order: k=0 is mac[47:40].
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < MAC_BYTES; i++) begin
      if (k == 6'(i)) b = mac[47-8*i -: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 step over one RMII dibit.
// Ports:
//   crc_in  [31:0] : current CRC register
//   dibit   [1:0]  : received dibit, dibit[0] is the earlier bit on the wire
//   crc_out [31:0] : CRC register after both bits have been absorbed
// No inversion is applied; callers compare against the fixed residue.
module crc32_dibit
  import rmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY;
      else                 c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/rmii_frame_rx.sv
// RMII receive front end for the Ethernet debug interface.
// Locks on preamble/SFD, deserializes a fixed 64-byte frame, filters on
// destination MAC and ethertype, checks the FCS residue and presents
// bytes 12..18 of an accepted frame as a 56-bit payload.
// Ports:
//   clk     : 50 MHz RMII reference clock, rising edge
//   rst     : synchronous active-high reset
//   crsdv   : RMII carrier-sense / data-valid
//   rxd[1:0]: RMII receive dibit, rxd[0] earlier on the wire
//   payload : {byte12 .. byte18} of the last accepted frame
//   valid   : one-cycle pulse when payload has been updated
module rmii_frame_rx
  import rmii_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC  = 48'h0,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic [55:0] payload,
  output logic        valid
);

  rx_state_e   state_q, state_d;
  logic [4:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic        mac_ok_q, mac_ok_d;
  logic        type_ok_q, type_ok_d;
  logic [7:0]  byte_q, byte_d;
  logic [55:0] staging_q, staging_d;
  logic [55:0] payload_q, payload_d;
  logic        valid_q, valid_d;

  logic [7:0]  byte_now;
  logic [5:0]  byte_idx;
  logic        byte_done;

  crc32_dibit u_crc (
    .crc_in  (crc_q),
    .dibit   (rxd),
    .crc_out (crc_next)
  );

  // LSB-first assembly: the newest dibit lands in the top bits, so after
  // four dibits the first one received sits in byte[1:0].
  assign byte_now  = {rxd, byte_q[7:2]};
  assign byte_idx  = cnt_q[7:2];
  assign byte_done = (cnt_q[1:0] == 2'b11);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    mac_ok_d  = mac_ok_q;
    type_ok_d = type_ok_q;
    byte_d    = byte_q;
    staging_d = staging_q;
    payload_d = payload_q;
    valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (crsdv) begin
          if (rxd == 2'b01) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 5'd1;
          end else if (rxd != 2'b00) begin
            state_d = WAIT_IDLE;
          end
        end
      end

      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else begin
          unique case (rxd)
            2'b01: begin
              if (pre_cnt_q != 5'(PRE_CNT_MAX)) pre_cnt_d = pre_cnt_q + 5'd1;
            end
            2'b11: begin
              if (pre_cnt_q >= 5'(MIN_PREAMBLE_DIBITS)) begin
                state_d   = FRAME;
                cnt_d     = '0;
                crc_d     = CRC_INIT;
                mac_ok_d  = 1'b1;
                type_ok_d = 1'b1;
              end else begin
                state_d = WAIT_IDLE;
              end
            end
            default: state_d = WAIT_IDLE;
          endcase
        end
      end

      FRAME: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else begin
          byte_d = byte_now;
          crc_d  = crc_next;
          cnt_d  = cnt_q + 8'd1;
          if (byte_done) begin
            if (byte_idx < 6'(DST_OFS + MAC_BYTES))
              mac_ok_d = mac_ok_q & (byte_now == mac_byte(FPGA_MAC, byte_idx));
            if (byte_idx == 6'(TYPE_OFS))
              type_ok_d = type_ok_q & (byte_now == ETHERTYPE[15:8]);
            if (byte_idx == 6'(TYPE_OFS + 1))
              type_ok_d = type_ok_q & (byte_now == ETHERTYPE[7:0]);
            // Bytes arrive in order, so shifting in yields byte12 at the top.
            if (byte_idx >= 6'(PAYLOAD_FIRST) && byte_idx <= 6'(PAYLOAD_LAST))
              staging_d = {staging_q[47:0], byte_now};
          end
          // 8-bit counter wraps exactly at the frame length.
          if (cnt_q == 8'(FRAME_DIBITS - 1)) state_d = CHECK;
        end
      end

      CHECK: begin
        if (mac_ok_q && type_ok_q && (crc_q == CRC_RESIDUE)) begin
          payload_d = staging_q;
          valid_d   = 1'b1;
        end
        state_d = WAIT_IDLE;
      end

      WAIT_IDLE: begin
        if (!crsdv) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      crc_q     <= CRC_INIT;
      mac_ok_q  <= 1'b1;
      type_ok_q <= 1'b1;
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      mac_ok_q  <= mac_ok_d;
      type_ok_q <= type_ok_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
    end
  end

  // Assembly datapath; every frame fully rewrites it before use
  always_ff @(posedge clk) begin
    byte_q    <= byte_d;
    staging_q <= staging_d;
  end

  assign payload = payload_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_rmii_frame_rx.sv
module tb_rmii_frame_rx;

  localparam logic [47:0] MAC  = 48'h123456789ABC;
  localparam logic [15:0] ETYP = 16'h88B5;
  localparam int MAXC = 24000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic [55:0] payload;
  logic        valid;

  rmii_frame_rx #(.FPGA_MAC(MAC), .ETHERTYPE(ETYP)) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .payload(payload), .valid(valid)
  );

  always #10 clk = ~clk;

  // Stimulus timeline and expected events, one entry per clock
  bit          s_crs [MAXC];
  logic [1:0]  s_rxd [MAXC];
  bit          s_rst [MAXC];
  bit          e_v   [MAXC];
  logic [55:0] e_new [MAXC];
  int          n = 0;

  logic [7:0]  fb [80];
  int          acc_cnt = 0;
  int          last_l = -1;
  int          pin_idx = -1;

  int checks = 0;
  int errors = 0;
  int drv_idx = -1;
  bit running = 1'b0;
  int dut_vcnt = 0;
  logic [55:0] exp_pl = '0;

  // Reference CRC-32 over fb[first..last], byte-wise, with final inversion
  function automatic logic [31:0] crc_range(input int first, input int last);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = first; i <= last; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic set_fcs(input int at);
    logic [31:0] c;
    c = crc_range(0, at - 1);
    fb[at]   = c[7:0];
    fb[at+1] = c[15:8];
    fb[at+2] = c[23:16];
    fb[at+3] = c[31:24];
  endtask

  task automatic fill_good(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] data);
    for (int i = 0; i < 80; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) fb[i] = 8'(MAC >> (8 * (5 - i)));
    fb[12] = ETYP[15:8];
    fb[13] = ETYP[7:0];
    fb[14] = op;
    fb[15] = addr[15:8];
    fb[16] = addr[7:0];
    fb[17] = data[15:8];
    fb[18] = data[7:0];
    set_fcs(60);
  endtask

  task automatic push(input bit c, input logic [1:0] d, input bit r);
    s_crs[n] = c;
    s_rxd[n] = d;
    s_rst[n] = r;
    n++;
  endtask

  // Drive one frame from fb and decide from frame-level rules whether it is accepted
  task automatic send_frame(input int nbytes, input int lead, input int npre,
                            input int abort_at, input int rst_at);
    int l;
    bit ok;
    logic [7:0] b;
    logic [31:0] fcs_rx;
    l = -1;
    for (int j = 0; j < lead; j++) push(1'b1, 2'b00, 1'b0);
    for (int j = 0; j < npre; j++) push(1'b1, 2'b01, 1'b0);
    push(1'b1, 2'b11, 1'b0);
    for (int j = 0; j < nbytes * 4; j++) begin
      if (j == abort_at) break;
      b = fb[j / 4];
      push(1'b1, b[2*(j%4) +: 2], j == rst_at);
      if (j == 255) l = n - 1;
    end
    fcs_rx = {fb[63], fb[62], fb[61], fb[60]};
    ok = (npre >= 8) && (abort_at < 0) && (rst_at < 0) && (l >= 0);
    for (int i = 0; i < 6; i++) if (fb[i] != 8'(MAC >> (8 * (5 - i)))) ok = 1'b0;
    if ({fb[12], fb[13]} != ETYP) ok = 1'b0;
    if (crc_range(0, 59) != fcs_rx) ok = 1'b0;
    last_l = l;
    if (ok) begin
      e_v[l + 1]   = 1'b1;
      e_new[l + 1] = {fb[12], fb[13], fb[14], fb[15], fb[16], fb[17], fb[18]};
      acc_cnt++;
    end
    for (int j = 0; j < int'($urandom_range(4, 10)); j++) push(1'b0, 2'b00, 1'b0);
  endtask

  // Compare process: checks every cycle against the model timeline
  always @(posedge clk) begin
    if (running && drv_idx >= 0) begin
      #1;
      if (s_rst[drv_idx])     exp_pl = '0;
      else if (e_v[drv_idx])  exp_pl = e_new[drv_idx];
      if (valid) dut_vcnt++;
      checks++;
      if (valid !== (e_v[drv_idx] && !s_rst[drv_idx])) begin
        errors++;
        $display("FAIL valid cyc=%0d got=%0b want=%0b", drv_idx, valid, e_v[drv_idx] && !s_rst[drv_idx]);
      end
      checks++;
      if (payload !== exp_pl) begin
        errors++;
        $display("FAIL payload cyc=%0d got=%h want=%h", drv_idx, payload, exp_pl);
      end
      if (drv_idx == 2) begin
        checks++;
        if (valid !== 1'b0 || payload !== 56'h0) begin
          errors++;
          $display("FAIL reset_state got valid=%0b payload=%h want 0/0", valid, payload);
        end
      end
      if (drv_idx == pin_idx) begin
        checks++;
        if (valid !== 1'b1 || payload !== 56'h88B5010004BEEF) begin
          errors++;
          $display("FAIL good_frame got valid=%0b payload=%h want 1/88b5010004beef", valid, payload);
        end
      end
    end
  end

  initial begin
    int lead, npre, ab, rs, nb, mode, k;

    // Pin the reference CRC against the standard check value
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    checks++;
    if (crc_range(0, 8) !== 32'hCBF43926) begin
      errors++;
      $display("FAIL crc_model got=%h want=cbf43926", crc_range(0, 8));
    end

    for (int i = 0; i < 3; i++) push(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 2; i++) push(1'b0, 2'b00, 1'b0);

    // Directed cases
    fill_good(8'h01, 16'h0004, 16'hBEEF);
    send_frame(64, 0, 31, -1, -1);
    pin_idx = last_l + 1;
    fill_good(8'h01, 16'h0004, 16'hBEEF); fb[40] ^= 8'h10;
    send_frame(64, 0, 31, -1, -1);
    fill_good(8'h02, 16'h1111, 16'h2222); fb[5] = 8'hBD; set_fcs(60);
    send_frame(64, 0, 31, -1, -1);
    fill_good(8'h02, 16'h1111, 16'h2222); fb[12] = 8'h08; fb[13] = 8'h00; set_fcs(60);
    send_frame(64, 0, 31, -1, -1);
    fill_good(8'h03, 16'h0100, 16'h5A5A);
    send_frame(64, 0, 31, 100, -1);
    fill_good(8'h03, 16'h0100, 16'hA5A5);
    send_frame(64, 0, 31, -1, -1);
    fill_good(8'h04, 16'h0200, 16'h0001);
    send_frame(64, 0, 5, -1, -1);
    send_frame(64, 0, 7, -1, -1);
    send_frame(64, 0, 8, -1, -1);
    fill_good(8'h05, 16'h0300, 16'h0002);
    send_frame(64, 3, 28, -1, -1);
    fill_good(8'h06, 16'h0400, 16'h0003);
    send_frame(64, 0, 31, -1, 150);
    fill_good(8'h07, 16'h0500, 16'h0004);
    send_frame(64, 0, 31, -1, -1);
    fill_good(8'h08, 16'h0600, 16'h0005);
    for (int i = 60; i < 64; i++) fb[i] = 8'($urandom);
    set_fcs(64);
    send_frame(68, 0, 31, -1, -1);

    checks++;
    if (acc_cnt != 5) begin
      errors++;
      $display("FAIL directed_accepts got=%0d want=5", acc_cnt);
    end

    // Randomized frames
    for (int r = 0; r < 32; r++) begin
      fill_good(8'($urandom), 16'($urandom), 16'($urandom));
      mode = int'($urandom_range(0, 10));
      lead = int'($urandom_range(0, 3));
      npre = int'($urandom_range(8, 31));
      ab = -1; rs = -1; nb = 64;
      case (mode)
        4: fb[$urandom_range(0, 63)] ^= 8'(1 << $urandom_range(0, 7));
        5: begin k = int'($urandom_range(0, 5)); fb[k] ^= 8'($urandom_range(1, 255)); set_fcs(60); end
        6: begin k = 12 + int'($urandom_range(0, 1)); fb[k] ^= 8'($urandom_range(1, 255)); set_fcs(60); end
        7: ab = int'($urandom_range(0, 255));
        8: rs = int'($urandom_range(0, 255));
        9: npre = int'($urandom_range(1, 7));
        10: begin
          nb = 64 + int'($urandom_range(1, 8));
          for (int i = 60; i < nb - 4; i++) fb[i] = 8'($urandom);
          set_fcs(nb - 4);
        end
        default: ;
      endcase
      send_frame(nb, lead, npre, ab, rs);
    end

    // Run the timeline
    running = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = s_rst[i];
      crsdv = s_crs[i];
      rxd = s_rxd[i];
      drv_idx = i;
    end
    @(negedge clk);
    @(negedge clk);
    running = 1'b0;

    checks++;
    if (dut_vcnt != acc_cnt) begin
      errors++;
      $display("FAIL valid_count got=%0d want=%0d", dut_vcnt, acc_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rmii_frame_rx.md
Name: rmii_frame_rx

Overview:
- RMII receive front end for the Ethernet debug interface.
- Watches crsdv/rxd, locks on preamble and SFD, and deserializes a fixed 64-byte frame.
- Filters on destination MAC and ethertype, and checks FCS.
- Presents the 7 bytes after the source MAC as a 56-bit payload with a one-cycle valid, which feeds the ethernet_rx request decoder.

Parameters:
- FPGA_MAC, 48'h0, destination MAC accepted; FPGA_MAC[47:40] is the first byte on the wire.
- ETHERTYPE, 16'h88B5, ethertype accepted; big-endian on the wire.

Ports:
- clk  in  1  50 MHz RMII reference clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- crsdv  in  1  RMII carrier-sense/data-valid.
- rxd  in  2  RMII receive dibit; rxd[0] is the earlier bit.
- payload  out  56  {byte12, byte13, …, byte18} of the last accepted frame; byte index counted from the first byte after SFD.
- valid  out  1  one-cycle pulse; payload is new and checked.

Behaviour:
- Wire order:
  - Bytes are sent LSB first, one dibit per clk, so each byte takes 4 cycles.
  - Preamble dibit is 2'b01; SFD ends with dibit 2'b11.
  - Frame after SFD is exactly 64 bytes (256 dibits):
    - bytes 0-5: destination MAC
    - bytes 6-11: source MAC (ignored)
    - bytes 12-13: ethertype
    - bytes 14-18: op, addr_hi, addr_lo, data_hi, data_lo
    - bytes 19-59: padding
    - bytes 60-63: FCS
- Reset: state=IDLE, payload=0, valid=0, dibit counter=0, CRC=32'hFFFFFFFF, match flags=1. Reset mid-frame aborts the frame; no valid is issued.
- FSM:
  - IDLE:
    - crsdv=1 and rxd=01: go to PREAMBLE, pre_cnt=1.
    - crsdv=1 and rxd=00: stay in IDLE (carrier before data).
    - crsdv=1 with any other dibit: go to WAIT_IDLE.
  - PREAMBLE:
    - rxd=01: pre_cnt++ (saturates at 31).
    - rxd=11 and pre_cnt>=8: SFD; go to FRAME with cnt=0, CRC=FFFFFFFF, mac_ok=1, type_ok=1.
    - rxd=11 with pre_cnt<8, or rxd 00/10: go to WAIT_IDLE.
    - crsdv=0: go to IDLE.
  - FRAME:
    - Each cycle: shift the dibit into the byte assembler, update CRC, cnt++.
    - At each completed byte k:
      - k<6: mac_ok &= (byte == FPGA_MAC byte k).
      - k=12,13: type_ok &= match against ETHERTYPE.
      - 12<=k<=18: write the byte into the staging register.
    - crsdv=0 before cnt reaches 256: abort to IDLE, no valid.
    - After the 256th dibit: go to CHECK.
  - CHECK (1 cycle):
    - If mac_ok & type_ok & (CRC==32'hDEBB20E3): payload<=staging and valid=1 on this cycle.
    - Always go to WAIT_IDLE.
  - WAIT_IDLE: stay until crsdv=0, then go to IDLE. Trailing dibits of longer frames are ignored here.
- Latency: valid is asserted 1 cycle after the clk edge that samples the last FCS dibit.
- CRC:
  - Reflected CRC-32, polynomial 32'hEDB88320, 2 bits per cycle, rxd[0] processed first.
  - No final inversion. The residue after the FCS bytes must equal 32'hDEBB20E3.
- Frames longer than 64 bytes fail the FCS check and are dropped; no special length logic.
- payload holds its value between valids; a rejected frame never modifies it.
- valid is never asserted on two consecutive cycles.

Decomposition:
- Shared package rmii_pkg:
  - state enum (IDLE, PREAMBLE, FRAME, CHECK, WAIT_IDLE)
  - FRAME_DIBITS=256, MIN_PREAMBLE_DIBITS=8
  - CRC_POLY=32'hEDB88320, CRC_RESIDUE=32'hDEBB20E3
  - byte offsets: DST=0, TYPE=12, PAYLOAD_FIRST=12, PAYLOAD_LAST=18
- Sub-module crc32_dibit:
  - Combinational next-CRC from {crc_in[31:0], dibit[1:0]}.
  - Reused later by the transmit path for FCS generation.

Test Plan:
- Good frame: FPGA_MAC=48'h12_34_56_78_9A_BC, ethertype 88B5, op=01, addr=0x0004, data=0xBEEF, correct FCS.
  - valid pulses once, 1 cycle after the last dibit.
  - payload=56'h88B5_01_0004_BEEF.
- Same frame with one flipped bit in padding byte 40 -> no valid; payload keeps its prior value.
- Destination MAC byte 5 = 0xBD, valid FCS -> no valid. Ethertype 0x0800 with valid FCS -> no valid.
- crsdv drops after 100 dibits, then a complete good frame follows -> exactly one valid, for the second frame.
- Preamble of only 5 dibits of 01 then SFD -> rejected. Leading 00 dibits while crsdv=1, then 28 preamble dibits -> accepted.
- rst asserted for 1 cycle at dibit 150 of a good frame -> no valid. Next good frame accepted; payload reset to 0 in between.
